// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with one write port, one read port and a shared clock.
// Features: per-byte write enables, a read latency of 1 or 2 with a valid
// flag, selectable read-during-write behaviour, and an optional
// clear-after-reset sequencer.
module sdp_ram_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int DEPTH          = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY     = 1,
  parameter int WRITE_FIRST    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             init_busy
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_wbe;

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  collide;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged_word;

  // Addresses at or beyond DEPTH fall outside the array and never touch it.
  assign wr_in_range = 32'(wr_addr) < DEPTH;
  assign rd_in_range = 32'(rd_addr) < DEPTH;
  assign rd_word     = rd_in_range ? mem[rd_addr] : '0;
  assign collide     = wr_en && wr_in_range && (wr_addr == rd_addr);

  // Word as it will look after this cycle's write: enabled lanes are taken
  // from wr_data and the remaining lanes from the stored word.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign merged_word[gi*BYTE_WIDTH +: BYTE_WIDTH] =
      wr_be[gi] ? wr_data[gi*BYTE_WIDTH +: BYTE_WIDTH]
                : rd_word[gi*BYTE_WIDTH +: BYTE_WIDTH];
  end

  // Next state: clear sequencer, write-port steering and read pipeline.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    mem_wbe    = wr_be;
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;       // data holds between reads
    s2_valid_d = s1_valid_q;      // second stage is a plain copy
    s2_data_d  = s1_data_q;
    case (state_q)
      CLEAR: begin
        // One zero word per cycle; user requests are ignored here.
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = READY;
          clr_cnt_d = '0;
        end
      end
      READY: begin
        mem_we = wr_en && wr_in_range;
        if (rd_en) begin
          s1_valid_d = 1'b1;
          if (!rd_in_range)
            s1_data_d = '0;
          else if ((WRITE_FIRST != 0) && collide)
            s1_data_d = merged_word;
          else
            s1_data_d = rd_word;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  // Control and read-pipeline registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      clr_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  // Storage array with per-lane writes; deliberately has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_wbe[i])
          mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_data   = (RD_LATENCY == 2) ? s2_data_q  : s1_data_q;
  assign rd_valid  = (RD_LATENCY == 2) ? s2_valid_q : s1_valid_q;
  assign init_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_sdp_ram_be.sv
// Randomized and directed bench for sdp_ram_be. Three instances share one
// set of stimulus: (lat1, read-first, 16 words), (lat2, write-first,
// 16 words) and (lat1, read-first, 12 words). Each instance is checked every
// cycle against a word-level reference model.
module tb_sdp_ram_be;

  localparam int ND = 3;
  localparam int LAT [ND] = '{1, 2, 1};
  localparam int WF  [ND] = '{0, 1, 0};
  localparam int DEP [ND] = '{16, 16, 12};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rdata  [ND];
  logic        rvalid [ND];
  logic        busy   [ND];

  always #5 clk = ~clk;

  sdp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16),
               .RD_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdata[0]), .rd_valid(rvalid[0]), .init_busy(busy[0]));

  sdp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16),
               .RD_LATENCY(2), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdata[1]), .rd_valid(rvalid[1]), .init_busy(busy[1]));

  sdp_ram_be #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12),
               .RD_LATENCY(1), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rdata[2]), .rd_valid(rvalid[2]), .init_busy(busy[2]));

  // Reference model: a plain word array, a remaining-clear-cycles count and a
  // queue of expected read results stamped with the cycle they must appear.
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  rd_t         rq       [ND][$];
  logic [31:0] mdl_mem  [ND][16];
  int          mdl_busy [ND];
  logic [31:0] mdl_last [ND];
  int          cyc;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      rq[d].delete();
      mdl_last[d] = '0;
      mdl_busy[d] = DEP[d];
      for (int a = 0; a < 16; a++) mdl_mem[d][a] = '0;
    end
  endtask

  // Effect of one rising edge with reset released.
  task automatic model_edge();
    logic [31:0] v;
    rd_t         e;
    cyc++;
    for (int d = 0; d < ND; d++) begin
      if (mdl_busy[d] > 0) begin
        mdl_busy[d]--;
      end else begin
        if (rd_en) begin
          v = (int'(rd_addr) < DEP[d]) ? mdl_mem[d][rd_addr] : 32'h0;
          if (WF[d] != 0 && wr_en && wr_addr == rd_addr && int'(wr_addr) < DEP[d])
            v = merge(v, wr_data, wr_be);
          e.due  = cyc + LAT[d] - 1;
          e.data = v;
          rq[d].push_back(e);
        end
        if (wr_en && int'(wr_addr) < DEP[d])
          mdl_mem[d][wr_addr] = merge(mdl_mem[d][wr_addr], wr_data, wr_be);
      end
    end
  endtask

  task automatic check_all();
    logic expv;
    rd_t  e;
    for (int d = 0; d < ND; d++) begin
      expv = 1'b0;
      if (rq[d].size() > 0 && rq[d][0].due == cyc) begin
        e           = rq[d].pop_front();
        mdl_last[d] = e.data;
        expv        = 1'b1;
      end
      chk($sformatf("busy%0d", d),  {31'b0, busy[d]},   {31'b0, mdl_busy[d] > 0});
      chk($sformatf("valid%0d", d), {31'b0, rvalid[d]}, {31'b0, expv});
      chk($sformatf("data%0d", d),  rdata[d],           mdl_last[d]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic re, input logic [3:0] ra);
    wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd; rd_en = re; rd_addr = ra;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
  endtask

  // Assert reset, check the asynchronous effect, hold two edges, release.
  task automatic do_reset();
    wr_en = 1'b0; rd_en = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_data%0d", d),  rdata[d],           32'h0);
      chk($sformatf("rst_valid%0d", d), {31'b0, rvalid[d]}, 32'h0);
      chk($sformatf("rst_busy%0d", d),  {31'b0, busy[d]},   32'h1);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    #2;
    do_reset();
    idle(16);

    // Freshly cleared array reads as zero everywhere.
    for (int a = 0; a < 16; a++) drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(a));
    idle(2);

    // Byte-lane merge on a single word.
    drive(1'b1, 4'd3, 4'b1111, 32'hDEADBEEF, 1'b0, 4'd0);
    drive(1'b1, 4'd3, 4'b0001, 32'h000000AA, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd3);
    chk("be_merge_lat1", rdata[0], 32'hDEADBEAA);
    idle(1);
    chk("be_merge_lat2", rdata[1], 32'hDEADBEAA);
    idle(1);

    // Same-edge read and write to one address.
    drive(1'b1, 4'd5, 4'b1111, 32'h11223344, 1'b0, 4'd0);
    drive(1'b1, 4'd5, 4'b1100, 32'hAABBCCDD, 1'b1, 4'd5);
    chk("collide_rdfirst", rdata[0], 32'h11223344);
    idle(1);
    chk("collide_wrfirst", rdata[1], 32'hAABB3344);
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd5);
    chk("after_collide", rdata[0], 32'hAABB3344);
    idle(2);

    // Streaming reads at full throughput.
    for (int a = 0; a < 8; a++) drive(1'b1, 4'(a), 4'b1111, $urandom, 1'b0, 4'd0);
    for (int a = 0; a < 8; a++) drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(a));
    idle(4);

    // Out-of-range accesses on the 12-word instance.
    drive(1'b1, 4'd11, 4'b1111, 32'hCAFEF00D, 1'b0, 4'd0);
    drive(1'b1, 4'd14, 4'b1111, 32'h12345678, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd14);
    chk("oor_read", rdata[2], 32'h0);
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd11);
    chk("oor_neighbour", rdata[2], 32'hCAFEF00D);
    idle(2);

    // Reset in the middle of a clear restarts the clear from address zero.
    drive(1'b1, 4'd12, 4'b1111, 32'h00000055, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd12);
    idle(2);
    do_reset();
    idle(7);
    do_reset();
    idle(16);
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd12);
    chk("restart_clear", rdata[0], 32'h0);
    idle(2);

    // Random traffic with a bias towards address collisions.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] wa;
      wa = 4'($urandom_range(0, 15));
      drive(1'($urandom), wa, 4'($urandom), $urandom, 1'($urandom),
            ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
